// File: rtl/shift_issue_stage.sv
// rtl/shift_issue_stage.sv - EX front end for sll/sllv: 2-entry operand queue, barrel shifter drive, result register
module shift_issue_stage #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_op,
  input  logic [31:0] in_rt,
  input  logic [31:0] in_rs,
  input  logic [4:0]  in_shamt,
  input  logic [4:0]  in_rd,
  output logic [31:0] sh_a,
  output logic [4:0]  sh_b,
  input  logic [31:0] sh_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic [1:0]  occupancy
);

  logic [31:0] q_rt  [DEPTH];
  logic [4:0]  q_amt [DEPTH];
  logic [4:0]  q_rd  [DEPTH];
  logic        head;
  logic        tail;
  logic [1:0]  count;

  logic        accept;
  logic        push;
  logic        issue;
  logic        not_empty;
  logic [4:0]  amount;

  assign not_empty = (count != 2'd0);
  assign in_ready  = (count != 2'(DEPTH));
  assign occupancy = count;

  // The shift amount is resolved at accept so the queue only carries one 5-bit field.
  assign amount = in_op ? in_rs[4:0] : in_shamt;
  assign accept = in_valid & in_ready & ~flush;
  // $zero destinations complete the handshake but never occupy a slot.
  assign push   = accept & (in_rd != 5'd0);
  assign issue  = not_empty & (~out_valid | out_ready) & ~flush;

  assign sh_a = not_empty ? q_rt[head]  : 32'd0;
  assign sh_b = not_empty ? q_amt[head] : 5'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      out_valid <= 1'b0;
      out_data  <= 32'd0;
      out_rd    <= 5'd0;
      for (int i = 0; i < DEPTH; i++) begin
        q_rt[i]  <= 32'd0;
        q_amt[i] <= 5'd0;
        q_rd[i]  <= 5'd0;
      end
    end else if (flush) begin
      head      <= 1'b0;
      tail      <= 1'b0;
      count     <= 2'd0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        q_rt[tail]  <= in_rt;
        q_amt[tail] <= amount;
        q_rd[tail]  <= in_rd;
        tail        <= ~tail;
      end
      if (issue) begin
        out_data  <= sh_out;
        out_rd    <= q_rd[head];
        out_valid <= 1'b1;
        head      <= ~head;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      count <= count + {1'b0, push} - {1'b0, issue};
    end
  end

endmodule

// File: tb/tb_shift_issue_stage.sv
// tb/tb_shift_issue_stage.sv - scoreboard bench for shift_issue_stage with a behavioural barrel shifter
module tb_shift_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        in_op;
  logic [31:0] in_rt;
  logic [31:0] in_rs;
  logic [4:0]  in_shamt;
  logic [4:0]  in_rd;
  logic [31:0] sh_a;
  logic [4:0]  sh_b;
  logic [31:0] sh_out;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic [1:0]  occupancy;

  int n_cmp = 0;
  int n_err = 0;
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  assign sh_out = sh_a << sh_b;

  shift_issue_stage #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rt(in_rt), .in_rs(in_rs), .in_shamt(in_shamt), .in_rd(in_rd),
    .sh_a(sh_a), .sh_b(sh_b), .sh_out(sh_out),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_rd(out_rd), .occupancy(occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Offers one op from the next falling edge; it is accepted at the first rising edge with in_ready high.
  task automatic drive(input logic op, input logic [31:0] rt, input logic [31:0] rs,
                       input logic [4:0] shamt, input logic [4:0] rd, input logic [31:0] res,
                       input bit want, input bit must_ready);
    int w;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_rt = rt; in_rs = rs; in_shamt = shamt; in_rd = rd;
    if (must_ready) check("in_ready_stays_high", {31'd0, in_ready}, 32'd1);
    w = 0;
    while (!in_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!in_ready) check("accept_timeout", 32'd0, 32'd1);
    else if (want && rd != 5'd0) exp_q.push_back({rd, res});
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin : monitor
    logic [36:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result_rd", {27'd0, out_rd}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e[31:0]);
          check("out_rd", {27'd0, out_rd}, {27'd0, e[36:32]});
        end
      end
    end
  end

  initial begin : stim
    int w;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_op = 1'b0;
    in_rt = 32'd0; in_rs = 32'd0; in_shamt = 5'd0; in_rd = 5'd0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_sh_a", sh_a, 32'd0);
    check("rst_sh_b", {27'd0, sh_b}, 32'd0);
    rst = 1'b0;

    // sll with latency check
    drive(1'b0, 32'h0000_0001, 32'd0, 5'd4, 5'd3, 32'h0000_0010, 1, 0);
    idle();
    check("latency_one_edge_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_two_edges_out_valid", {31'd0, out_valid}, 32'd1);

    drive(1'b1, 32'hF000_000F, 32'h0000_0023, 5'd31, 5'd7, 32'h8000_0078, 1, 0);
    drive(1'b0, 32'hDEAD_BEEF, 32'd0, 5'd0, 5'd9, 32'hDEAD_BEEF, 1, 0);
    idle();
    repeat (4) @(negedge clk);

    // backpressure: A, B, C fill the stage, D waits
    out_ready = 1'b0;
    drive(1'b0, 32'h0000_0003, 32'd0, 5'd1, 5'd1, 32'h0000_0006, 1, 0);
    drive(1'b1, 32'h8000_0001, 32'hFFFF_FFE1, 5'd0, 5'd2, 32'h0000_0002, 1, 0);
    drive(1'b0, 32'h1234_5678, 32'd0, 5'd8, 5'd4, 32'h3456_7800, 1, 0);
    @(negedge clk);
    in_valid = 1'b1; in_op = 1'b0; in_rt = 32'hFFFF_FFFF; in_shamt = 5'd31; in_rd = 5'd5;
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    check("bp_occupancy_full", {30'd0, occupancy}, 32'd2);
    repeat (3) @(negedge clk);
    check("bp_occupancy_held", {30'd0, occupancy}, 32'd2);
    check("bp_out_valid_held", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    drive(1'b0, 32'hFFFF_FFFF, 32'd0, 5'd31, 5'd5, 32'h8000_0000, 1, 0);
    idle();
    repeat (6) @(negedge clk);

    // rd == 0 is accepted but discarded
    drive(1'b0, 32'h0000_0001, 32'd0, 5'd5, 5'd5, 32'h0000_0020, 1, 1);
    drive(1'b0, 32'hAAAA_AAAA, 32'd0, 5'd1, 5'd0, 32'd0, 1, 1);
    drive(1'b0, 32'h0000_0007, 32'd0, 5'd2, 5'd6, 32'h0000_001C, 1, 1);
    idle();
    repeat (5) @(negedge clk);

    // flush with full stage and an op offered in the same cycle
    out_ready = 1'b0;
    drive(1'b0, 32'h1111_1111, 32'd0, 5'd1, 5'd10, 32'd0, 0, 0);
    drive(1'b0, 32'h2222_2222, 32'd0, 5'd1, 5'd11, 32'd0, 0, 0);
    drive(1'b0, 32'h3333_3333, 32'd0, 5'd1, 5'd12, 32'd0, 0, 0);
    @(negedge clk);
    check("pre_flush_occupancy", {30'd0, occupancy}, 32'd2);
    check("pre_flush_out_valid", {31'd0, out_valid}, 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_rt = 32'h4444_4444; in_shamt = 5'd1; in_rd = 5'd13;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("flush_occupancy", {30'd0, occupancy}, 32'd0);
    check("flush_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("flush_no_late_op", {30'd0, occupancy}, 32'd0);
    check("flush_no_late_result", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 32'h0000_00FF, 32'h0000_0004, 5'd0, 5'd14, 32'h0000_0FF0, 1, 0);
    idle();
    repeat (4) @(negedge clk);

    // asynchronous reset with two queued and one result pending
    out_ready = 1'b0;
    drive(1'b0, 32'h5555_5555, 32'd0, 5'd2, 5'd15, 32'd0, 0, 0);
    drive(1'b0, 32'h6666_6666, 32'd0, 5'd2, 5'd16, 32'd0, 0, 0);
    drive(1'b0, 32'h7777_7777, 32'd0, 5'd2, 5'd17, 32'd0, 0, 0);
    idle();
    check("pre_rst_occupancy", {30'd0, occupancy}, 32'd2);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("async_rst_occupancy", {30'd0, occupancy}, 32'd0);
    check("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("async_rst_out_data", out_data, 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
    drive(1'b0, 32'h0000_0ABC, 32'd0, 5'd12, 5'd18, 32'h00AB_C000, 1, 0);
    idle();

    w = 0;
    while (exp_q.size() != 0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
